// File: rtl/adc_sclk_pkg.sv
// -----------------------------------------------------------------------------
// adc_sclk_pkg
// Shared definitions for the ADC serial-clock generator:
//   - state_t       : controller states (SETUP/HOLD are used only when the
//                     chip-select framing option is compiled in)
//   - ADC_DIV_W_DEF : default divider width
//   - ADC_CNT_W_DEF : default burst-length width
//   - edge_cnt_w()  : width of the edge counter, which holds 2*NUM_BITS
// -----------------------------------------------------------------------------
package adc_sclk_pkg;

  localparam int ADC_DIV_W_DEF = 8;
  localparam int ADC_CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // A burst of N bits has 2*N SCLK edges, so one extra bit is needed.
  function automatic int edge_cnt_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/adc_sclk_div.sv
// -----------------------------------------------------------------------------
// adc_sclk_div
// Reloadable down-counter used as the SCLK half-period timer.
//   clk   : system clock
//   rst   : synchronous reset, active-high (count cleared to 0)
//   load  : load 'value' into the counter this cycle
//   value : reload value (half-period minus one)
//   tick  : high while the count is 0; the counter parks at 0 when not loaded
// -----------------------------------------------------------------------------
module adc_sclk_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tick
);

  logic [W-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/adc_sclk_gen.sv
// -----------------------------------------------------------------------------
// adc_sclk_gen
// Serial-clock generator for the ADC / touch-controller serial interface.
// Produces a burst of exactly NUM_BITS SCLK periods per START, with a
// programmable half-period (DIV+1 CLK cycles) and selectable idle polarity.
//
// Ports:
//   CLK       : system clock
//   RST       : synchronous reset, active-high
//   START     : one-cycle burst request, sampled only while idle
//   ABORT     : terminate a running burst on the next edge
//   DIV       : half-period minus one, latched at START
//   NUM_BITS  : SCLK periods per burst, latched at START (0 = DONE only)
//   CPOL      : idle level of SCLK, latched at START
//   SCLK      : registered serial clock
//   LEAD_STB  : high the cycle SCLK has just left its idle level
//   TRAIL_STB : high the cycle SCLK has just returned to its idle level
//   BUSY      : burst in progress
//   DONE      : one-cycle pulse when a burst completes
//   CS_n      : active-low chip select (only with ADC_SCLK_CS_EN)
//
// Build option ADC_SCLK_CS_EN adds CS_n and wraps RUN with SETUP and HOLD
// phases of DIV+1 cycles each; CS_n is low from START-accept to end of HOLD.
// -----------------------------------------------------------------------------
module adc_sclk_gen
  import adc_sclk_pkg::*;
#(
  parameter int DIV_W = ADC_DIV_W_DEF,
  parameter int CNT_W = ADC_CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [DIV_W-1:0] DIV,
  input  logic [CNT_W-1:0] NUM_BITS,
  input  logic             CPOL,
  output logic             SCLK,
  output logic             LEAD_STB,
  output logic             TRAIL_STB,
  output logic             BUSY,
  output logic             DONE
`ifdef ADC_SCLK_CS_EN
  ,
  output logic             CS_n
`endif
);

  localparam int EDGE_W = edge_cnt_w(CNT_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(1);

`ifdef ADC_SCLK_CS_EN
  localparam state_t ST_FIRST   = ST_SETUP;
  localparam state_t ST_AFTER   = ST_HOLD;
  localparam bit     DONE_AT_RUN = 1'b0;
`else
  localparam state_t ST_FIRST   = ST_RUN;
  localparam state_t ST_AFTER   = ST_IDLE;
  localparam bit     DONE_AT_RUN = 1'b1;
`endif

  state_t              state;
  logic [DIV_W-1:0]    div_q;
  logic                cpol_q;
  logic [EDGE_W-1:0]   edge_cnt;   // remaining SCLK edges; holds the latched burst length
  logic                tick;
  logic                start_req;
  logic                start_acc;
  logic                div_load;
  logic [DIV_W-1:0]    div_value;

  // ABORT beats START in IDLE; a zero-length request only latches CPOL.
  assign start_req = (state == ST_IDLE) && START && !ABORT;
  assign start_acc = start_req && (NUM_BITS != '0);

  // The divider is primed on accept and reloaded on every expiry while active,
  // so each phase (SETUP, every half-period, HOLD) lasts exactly DIV+1 cycles.
  assign div_load  = start_acc || ((state != ST_IDLE) && tick);
  assign div_value = start_acc ? DIV : div_q;

  assign BUSY = (state != ST_IDLE);

  adc_sclk_div #(.W(DIV_W)) u_div (
    .clk   (CLK),
    .rst   (RST),
    .load  (div_load),
    .value (div_value),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      edge_cnt  <= '0;
      SCLK      <= 1'b0;
      LEAD_STB  <= 1'b0;
      TRAIL_STB <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      LEAD_STB  <= 1'b0;
      TRAIL_STB <= 1'b0;
      DONE      <= 1'b0;
      if (state == ST_IDLE) begin
        if (start_req) begin
          cpol_q <= CPOL;
          SCLK   <= CPOL;
          if (start_acc) begin
            div_q    <= DIV;
            edge_cnt <= {NUM_BITS, 1'b0};
            state    <= ST_FIRST;
          end else begin
            DONE <= 1'b1;
          end
        end else begin
          SCLK <= cpol_q;
        end
      end else if (ABORT) begin
        state <= ST_IDLE;
        SCLK  <= cpol_q;
      end else if (tick) begin
        case (state)
          ST_SETUP: state <= ST_RUN;
          ST_RUN: begin
            SCLK      <= ~SCLK;
            // Strobes are judged against the pre-toggle level, so they line
            // up with the cycle SCLK shows its new value.
            LEAD_STB  <= (SCLK == cpol_q);
            TRAIL_STB <= (SCLK != cpol_q);
            edge_cnt  <= edge_cnt - EDGE_W'(1);
            if (edge_cnt == LAST_EDGE) begin
              state <= ST_AFTER;
              if (DONE_AT_RUN) DONE <= 1'b1;
            end
          end
          ST_HOLD: begin
            state <= ST_IDLE;
            DONE  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ADC_SCLK_CS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      CS_n <= 1'b1;
    end else if (start_acc) begin
      CS_n <= 1'b0;
    end else if ((state != ST_IDLE) && (ABORT || ((state == ST_HOLD) && tick))) begin
      CS_n <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_sclk_gen.sv
// -----------------------------------------------------------------------------
// tb_adc_sclk_gen
// Directed bench for adc_sclk_gen. Each step drives inputs after a rising
// edge and checks outputs 1 ns later. Expected per-cycle outputs come from the
// burst timing formula: toggle n lands at START-edge + (n + setup)*(DIV+1),
// DONE at the last toggle (plus HOLD when chip-select framing is built in).
// Builds with or without ADC_SCLK_CS_EN.
// -----------------------------------------------------------------------------
module tb_adc_sclk_gen;

`ifdef ADC_SCLK_CS_EN
  localparam int CS_EN = 1;
`else
  localparam int CS_EN = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] DIV = '0;
  logic [5:0] NUM_BITS = '0;
  logic       CPOL = 1'b0;
  logic       SCLK, LEAD_STB, TRAIL_STB, BUSY, DONE;
`ifdef ADC_SCLK_CS_EN
  logic       CS_n;
`endif

  int vectors = 0;
  int miscompares = 0;

  adc_sclk_gen dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .ABORT     (ABORT),
    .DIV       (DIV),
    .NUM_BITS  (NUM_BITS),
    .CPOL      (CPOL),
    .SCLK      (SCLK),
    .LEAD_STB  (LEAD_STB),
    .TRAIL_STB (TRAIL_STB),
    .BUSY      (BUSY),
    .DONE      (DONE)
`ifdef ADC_SCLK_CS_EN
    ,
    .CS_n      (CS_n)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Packs {SCLK, LEAD_STB, TRAIL_STB, BUSY, DONE}; CS_n is checked as ~BUSY.
  task automatic check_vec(input string tag, input int j, input logic [7:0] expv);
    check($sformatf("%s j=%0d", tag, j), {3'b000, SCLK, LEAD_STB, TRAIL_STB, BUSY, DONE}, expv);
`ifdef ADC_SCLK_CS_EN
    check($sformatf("%s cs_n j=%0d", tag, j), {7'd0, CS_n}, {7'd0, ~expv[1]});
`endif
  endtask

  // Expected outputs j cycles after the START-accept edge.
  function automatic logic [7:0] exp_vec(input int d, input int n, input bit cp, input int j);
    int   per, off, done_j, m;
    logic lead, trail, busy, done;
    per    = d + 1;
    off    = CS_EN * per;
    done_j = (n == 0) ? 0 : (2 * n * per + 2 * off);
    m = 0; lead = 1'b0; trail = 1'b0;
    for (int i = 1; i <= 2 * n; i++) begin
      if (off + i * per <= j) m++;
      if (off + i * per == j) begin
        if (i % 2 == 1) lead = 1'b1;
        else            trail = 1'b1;
      end
    end
    busy = (n != 0) && (j < done_j);
    done = (j == done_j);
    return {3'b000, cp ^ m[0], lead, trail, busy, done};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Full burst from START-accept to the DONE cycle. After accept the inputs
  // are scrambled and a stray START is pulsed mid-burst; neither may matter.
  // Returns in the DONE cycle, so a following call issues a coincident START.
  task automatic run_burst(input int d, input int n, input bit cp, input string tag);
    int done_j;
    done_j   = (n == 0) ? 0 : (2 * n * (d + 1) + 2 * CS_EN * (d + 1));
    DIV      = 8'(d);
    NUM_BITS = 6'(n);
    CPOL     = cp;
    START    = 1'b1;
    for (int j = 0; j <= done_j; j++) begin
      step();
      if (j == 0) begin
        START    = 1'b0;
        DIV      = 8'(d + 3);
        NUM_BITS = 6'(n + 1);
        CPOL     = ~cp;
      end
      check_vec(tag, j, exp_vec(d, n, cp, j));
      if (j == 1) START = 1'b1;
      if (j == 2) START = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int cnt, input bit cp, input string tag);
    START = 1'b0;
    for (int j = 0; j < cnt; j++) begin
      step();
      check_vec(tag, j, {3'b000, cp, 4'b0000});
    end
  endtask

  initial begin
    // Reset state.
    RST = 1'b1;
    step();
    step();
    check_vec("reset", 0, 8'h00);
    RST = 1'b0;
    idle_cycles(2, 1'b0, "idle_after_reset");

    // CLK/2 burst, 16 toggles.
    run_burst(0, 8, 1'b0, "d0_n8_cpol0");
    idle_cycles(3, 1'b0, "idle_a");

    // Slow burst with SCLK idling high.
    run_burst(4, 3, 1'b1, "d4_n3_cpol1");
    idle_cycles(3, 1'b1, "idle_b");

    // ABORT sampled 7 edges into a DIV=2, N=5 burst.
    DIV = 8'd2; NUM_BITS = 6'd5; CPOL = 1'b1; START = 1'b1;
    for (int j = 0; j <= 7; j++) begin
      step();
      if (j == 0) START = 1'b0;
      if (j < 7) check_vec("abort_run", j, exp_vec(2, 5, 1'b1, j));
      else       check_vec("abort_hit", j, 8'b0001_0000);
      if (j == 6) ABORT = 1'b1;
    end
    ABORT = 1'b0;
    idle_cycles(20, 1'b1, "post_abort");

    // ABORT and START together in IDLE: START dropped, new CPOL not latched.
    DIV = 8'd1; NUM_BITS = 6'd4; CPOL = 1'b0; START = 1'b1; ABORT = 1'b1;
    step();
    check_vec("abort_start_idle", 0, 8'b0001_0000);
    START = 1'b0; ABORT = 1'b0;
    idle_cycles(2, 1'b1, "idle_c");

    // Normal burst accepted after the abort.
    run_burst(1, 2, 1'b0, "after_abort");
    idle_cycles(2, 1'b0, "idle_d");

    // Zero-length request: DONE next cycle, no SCLK activity.
    run_burst(3, 0, 1'b0, "n0");
    idle_cycles(4, 1'b0, "idle_e");

    // Back-to-back: START in the DONE cycle, polarity changes between bursts.
    run_burst(2, 3, 1'b0, "b2b_first");
    run_burst(1, 4, 1'b1, "b2b_second");
    idle_cycles(2, 1'b1, "idle_f");

    // Reset in the middle of a DIV=3, N=4 burst.
    DIV = 8'd3; NUM_BITS = 6'd4; CPOL = 1'b1; START = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      step();
      if (j == 0) START = 1'b0;
      check_vec("rst_mid_run", j, exp_vec(3, 4, 1'b1, j));
    end
    RST = 1'b1;
    step();
    check_vec("rst_mid_hit", 0, 8'h00);
    RST = 1'b0;
    idle_cycles(2, 1'b0, "idle_g");

    // Longest burst the default width allows.
    run_burst(0, 63, 1'b1, "n_max");
    idle_cycles(2, 1'b1, "idle_h");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
